// File: rtl/vend_sequencer.sv
// Vending front-end: coin credit, item select, dispense strobe and paced change train.
// Optional auto-refund after TIMEOUT idle cycles with credit: define VEND_AUTO_REFUND_EN.
module vend_sequencer #(
    parameter int unsigned PRICE_A    = 3,
    parameter int unsigned PRICE_B    = 2,
    parameter int unsigned CW         = 4,
    parameter int unsigned CREDIT_MAX = 15,
    parameter int unsigned CHANGE_GAP = 1,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic          Clk,
    input  logic          nrst,
    input  logic          coin1,
    input  logic          coin5,
    input  logic          sel_a,
    input  logic          sel_b,
    input  logic          cancel,
    output logic          disp_a,
    output logic          disp_b,
    output logic          change,
    output logic          coin_reject,
    output logic          deny,
    output logic [CW-1:0] credit,
    output logic          busy
);

    localparam int unsigned SW = CW + 3;
    localparam int unsigned GW = (CHANGE_GAP > 1) ? $clog2(CHANGE_GAP) : 1;

    typedef enum logic [1:0] {IDLE, DISPENSE, CHANGE, GAP} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] credit_nx;
    logic [GW-1:0] gap_cnt, gap_nx;
    logic          disp_a_nx, disp_b_nx, change_nx, reject_nx, deny_nx;
    logic [SW-1:0] coin_v, sum, eff, price;
    logic          coin_ok, activity;

`ifdef VEND_AUTO_REFUND_EN
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [TW-1:0] tmo_cnt, tmo_nx;
`endif

    always_comb begin
        state_nx  = state;
        credit_nx = credit;
        gap_nx    = '0;
        disp_a_nx = 1'b0;
        disp_b_nx = 1'b0;
        reject_nx = 1'b0;
        deny_nx   = 1'b0;
        coin_v    = '0;
        sum       = '0;
        eff       = '0;
        price     = '0;
        coin_ok   = 1'b0;
        activity  = 1'b0;
`ifdef VEND_AUTO_REFUND_EN
        tmo_nx    = '0;
`endif
        case (state)
            IDLE: begin
                coin_v    = coin5 ? SW'(5) : (coin1 ? SW'(1) : '0);
                reject_nx = coin5 & coin1;
                sum       = SW'(credit) + coin_v;
                if (sum > SW'(CREDIT_MAX)) begin
                    reject_nx = 1'b1;
                    eff       = SW'(credit);
                end else begin
                    eff     = sum;
                    coin_ok = (coin_v != '0);
                end
                // Selection sees this cycle's coin; selection outranks cancel.
                if (sel_a || sel_b) begin
                    activity = 1'b1;
                    price    = sel_a ? SW'(PRICE_A) : SW'(PRICE_B);
                    if (eff >= price) begin
                        state_nx  = DISPENSE;
                        credit_nx = CW'(eff - price);
                        disp_a_nx = sel_a;
                        disp_b_nx = ~sel_a;
                    end else begin
                        deny_nx   = 1'b1;
                        credit_nx = CW'(eff);
                    end
                end else if (cancel && eff != '0) begin
                    activity  = 1'b1;
                    state_nx  = CHANGE;
                    credit_nx = CW'(eff);
                end else begin
                    credit_nx = CW'(eff);
                end
`ifdef VEND_AUTO_REFUND_EN
                if (coin_ok || activity || credit == '0) begin
                    tmo_nx = '0;
                end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                    state_nx = CHANGE;
                end else begin
                    tmo_nx = tmo_cnt + TW'(1);
                end
`endif
            end
            DISPENSE: state_nx = (credit != '0) ? CHANGE : IDLE;
            CHANGE: begin
                credit_nx = credit - CW'(1);
                if (credit_nx == '0)     state_nx = IDLE;
                else if (CHANGE_GAP > 0) state_nx = GAP;
                else                     state_nx = CHANGE;
            end
            GAP: begin
                if (gap_cnt == GW'(CHANGE_GAP - 1)) state_nx = CHANGE;
                else                                gap_nx   = gap_cnt + GW'(1);
            end
            default: state_nx = IDLE;
        endcase
        if (state != IDLE) reject_nx = coin1 | coin5;
        change_nx = (state_nx == CHANGE);
    end

    always_ff @(posedge Clk or posedge nrst) begin
        if (nrst) begin
            state       <= IDLE;
            credit      <= '0;
            gap_cnt     <= '0;
            disp_a      <= 1'b0;
            disp_b      <= 1'b0;
            change      <= 1'b0;
            coin_reject <= 1'b0;
            deny        <= 1'b0;
        end else begin
            state       <= state_nx;
            credit      <= credit_nx;
            gap_cnt     <= gap_nx;
            disp_a      <= disp_a_nx;
            disp_b      <= disp_b_nx;
            change      <= change_nx;
            coin_reject <= reject_nx;
            deny        <= deny_nx;
        end
    end

`ifdef VEND_AUTO_REFUND_EN
    always_ff @(posedge Clk or posedge nrst) begin
        if (nrst) tmo_cnt <= '0;
        else      tmo_cnt <= tmo_nx;
    end
`endif

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_vend_sequencer.sv
// Randomized scoreboard bench for vend_sequencer; expected strobes come from a
// transaction-level model that schedules whole change trains arithmetically.
module tb_vend_sequencer;

    localparam int PA = 3, PB = 2, CWID = 4, CMAX = 15, G = 1, TO = 64;

    logic            Clk = 1'b0;
    logic            nrst;
    logic            coin1, coin5, sel_a, sel_b, cancel;
    logic            disp_a, disp_b, change, coin_reject, deny, busy;
    logic [CWID-1:0] credit;

    vend_sequencer #(
        .PRICE_A(PA), .PRICE_B(PB), .CW(CWID), .CREDIT_MAX(CMAX),
        .CHANGE_GAP(G), .TIMEOUT(TO)
    ) dut (
        .Clk(Clk), .nrst(nrst), .coin1(coin1), .coin5(coin5), .sel_a(sel_a),
        .sel_b(sel_b), .cancel(cancel), .disp_a(disp_a), .disp_b(disp_b),
        .change(change), .coin_reject(coin_reject), .deny(deny),
        .credit(credit), .busy(busy)
    );

    always #5 Clk = ~Clk;

    // strb = {disp_a, disp_b, change, coin_reject, deny}
    typedef struct {
        int         cyc;
        logic [4:0] strb;
        int         cred;
        logic       bsy;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0, failures = 0, cyc = 0;
    int   m_credit = 0, busy_until = 0, last_act = 0;
    bit   sched_chg[int];
    int   sched_cred[int];

    function automatic void check(string name, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
        end
    endfunction

    // r change pulses starting at cycle 'first', one every G+1 cycles.
    function automatic void train(int n, int first, int r);
        busy_until = first + (r - 1) * (G + 1) + 1;
        for (int k = 0; k < r; k++) sched_chg[first + k * (G + 1)] = 1'b1;
        for (int c = n + 1; c < busy_until; c++) begin
            int done = 0;
            for (int k = 0; k < r; k++) if (first + k * (G + 1) < c) done++;
            sched_cred[c] = r - done;
        end
        m_credit = 0;
    endfunction

    function automatic void step(int n, bit c1, bit c5, bit sa, bit sb, bit cn);
        exp_t e;
        int   v, eff, price;
        bit   act;
        e.cyc  = n + 1;
        e.strb = '0;
        act    = 1'b0;
        if (n < busy_until) begin
            if (c1 || c5) e.strb[1] = 1'b1;
        end else begin
            v = c5 ? 5 : (c1 ? 1 : 0);
            if (c1 && c5) e.strb[1] = 1'b1;
            if (v != 0 && m_credit + v <= CMAX) begin
                eff = m_credit + v;
                act = 1'b1;
            end else begin
                eff = m_credit;
                if (v != 0) e.strb[1] = 1'b1;
            end
            if (sa || sb) begin
                act   = 1'b1;
                price = sa ? PA : PB;
                if (eff >= price) begin
                    if (sa) e.strb[4] = 1'b1;
                    else    e.strb[3] = 1'b1;
                    if (eff == price) begin
                        busy_until    = n + 2;
                        sched_cred[n + 1] = 0;
                        m_credit      = 0;
                    end else begin
                        train(n, n + 2, eff - price);
                    end
                end else begin
                    e.strb[0] = 1'b1;
                    m_credit  = eff;
                end
            end else if (cn && eff > 0) begin
                act = 1'b1;
                train(n, n + 1, eff);
            end else begin
                m_credit = eff;
            end
            if (act) last_act = n;
`ifdef VEND_AUTO_REFUND_EN
            else if (m_credit > 0 && n - last_act == TO) train(n, n + 1, m_credit);
`endif
        end
        e.strb[2] = sched_chg.exists(n + 1);
        e.cred    = sched_cred.exists(n + 1) ? sched_cred[n + 1] : m_credit;
        e.bsy     = (n + 1 < busy_until);
        if (e.strb != '0) exp_q.push_back(e);
    endfunction

    task automatic check_state();
        check("busy", int'(busy), int'(cyc < busy_until));
        check("credit", int'(credit), sched_cred.exists(cyc) ? sched_cred[cyc] : m_credit);
    endtask

    task automatic cycle_in(bit c1, bit c5, bit sa, bit sb, bit cn);
        check_state();
        coin1 = c1; coin5 = c5; sel_a = sa; sel_b = sb; cancel = cn;
        step(cyc, c1, c5, sa, sb, cn);
        @(posedge Clk);
        cyc++;
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cycle_in(0, 0, 0, 0, 0);
    endtask

    task automatic rst_checks();
        check("rst_disp_a", int'(disp_a), 0);
        check("rst_disp_b", int'(disp_b), 0);
        check("rst_change", int'(change), 0);
        check("rst_reject", int'(coin_reject), 0);
        check("rst_deny", int'(deny), 0);
        check("rst_credit", int'(credit), 0);
        check("rst_busy", int'(busy), 0);
    endtask

    task automatic do_reset();
        coin1 = 0; coin5 = 0; sel_a = 0; sel_b = 0; cancel = 0;
        nrst = 1'b1;
        #1;
        rst_checks();
        m_credit = 0; busy_until = 0; last_act = 0;
        sched_chg.delete();
        sched_cred.delete();
        exp_q.delete();
        @(posedge Clk); cyc++;
        @(posedge Clk); cyc++;
        #1;
        nrst = 1'b0;
    endtask

    always @(negedge Clk) begin
        logic [4:0] s;
        exp_t       e;
        s = {disp_a, disp_b, change, coin_reject, deny};
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_strobe cyc=%0d actual=00000 required=%b", e.cyc, e.strb);
        end
        if (s != '0) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                check("strobes", int'(s), int'(e.strb));
                check("strobe_credit", int'(credit), e.cred);
                check("strobe_busy", int'(busy), int'(e.bsy));
            end else begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe cyc=%0d actual=%b required=00000", cyc, s);
            end
        end
    end

    initial begin
        nrst = 1'b1;
        coin1 = 0; coin5 = 0; sel_a = 0; sel_b = 0; cancel = 0;
        repeat (3) begin @(posedge Clk); cyc++; end
        #1;
        rst_checks();
        nrst = 1'b0;

        cycle_in(0, 1, 1, 0, 0); idle(6);                         // coin5+sel_a, 2 change
        cycle_in(1, 0, 0, 0, 0); idle(1);
        cycle_in(1, 0, 0, 0, 0); idle(1);
        cycle_in(0, 0, 0, 1, 0); idle(3);                         // exact price B
        cycle_in(1, 0, 0, 0, 0); cycle_in(0, 0, 1, 0, 0);         // deny
        cycle_in(1, 0, 0, 0, 0); cycle_in(1, 0, 0, 0, 0);
        cycle_in(0, 0, 1, 0, 0); idle(3);
        repeat (3) cycle_in(0, 1, 0, 0, 0);
        cycle_in(1, 0, 0, 0, 0);                                  // overflow reject
        cycle_in(0, 0, 0, 0, 1); idle(35);                        // 15-pulse refund
        cycle_in(0, 1, 0, 1, 0); idle(1);
        cycle_in(0, 1, 0, 0, 0); cycle_in(0, 0, 1, 0, 0);
        cycle_in(0, 0, 0, 0, 1); idle(6);                         // inputs while busy
        cycle_in(0, 1, 0, 1, 0); idle(2);
        do_reset(); idle(6);                                      // reset in first GAP
        cycle_in(1, 1, 0, 0, 0); cycle_in(0, 0, 0, 0, 1); idle(4);
`ifdef VEND_AUTO_REFUND_EN
        cycle_in(1, 0, 0, 0, 0); idle(TO + 5);
`endif
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 999) == 0) do_reset();
            else cycle_in($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10,
                          $urandom_range(0, 99) < 7, $urandom_range(0, 99) < 7,
                          $urandom_range(0, 99) < 4);
        end
        idle(TO + 60);
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
